controle_dispensador: RTL and testbench
=======================================

// Module: controle_dispensador
// PURPOSE
//  Sequential dispense controller for the coffee vending machine. It is the responder side
//  of the purchase verifier. It detects a drink-button press and latches the button and
//  bill-switch values, then presents them to the verifier. It samples the returned D_valor,
//  then either runs a timed preparation cycle or signals an error. Sits between the
//  debounced panel inputs and the LED/actuator outputs.
// PARAMETERS
//  T_PREPARO  8  cycles preparando stays high (>=1)
//  T_PRONTO   4  cycles pronto stays high (>=1)
//  T_ERRO     4  cycles erro stays high (>=1)
// PORTS
//  clk             in   1  system clock, rising edge
//  rst             in   1  asynchronous, active-high reset
//  bt              in   4  debounced drink buttons, active-high (B3 expresso, B2 camomila, B1 c/leite, B0 capuccino)
//  chaves_cedulas  in   3  bill/value switches
//  sel_bt          out  4  latched button, drives verifier bt
//  sel_cedulas     out  3  latched switches, drives verifier chaves_cedulas
//  D_valor         in   1  verifier result: 0 = value accepted, 1 = mismatch
//  bebida          out  4  one-hot drink being prepared (copy of sel_bt in PREPARA/PRONTO, else 0)
//  preparando      out  1  high during PREPARA
//  pronto          out  1  high during PRONTO
//  erro            out  1  high during ERRO
//  ocupado         out  1  high in every state except OCIOSO
//  vendas          out  8  completed-sale count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state OCIOSO. sel_bt=0, sel_cedulas=0, bebida=0, preparando/pronto/erro/ocupado=0, vendas=0.
//    The timer is 0. The previous-button register is set to 4'b1111, so a button held through
//    reset never triggers. Reset mid-operation aborts immediately with no partial output.
//  Edge detect: rise = bt & ~bt_prev. bt_prev is updated every cycle in all states.
//  OCIOSO: if rise != 0, latch sel_bt<=bt and sel_cedulas<=chaves_cedulas, then go to VERIFICA.
//    Rises in any other state are ignored and are not queued.
//  VERIFICA (exactly 1 cycle). D_valor is combinational from the sel_* outputs.
//    -> ERRO if popcount(sel_bt) != 1 (simultaneous presses), or sel_cedulas == 3'b000,
//       or D_valor == 1.
//    -> otherwise PREPARA.
//  PREPARA: timer counts T_PREPARO cycles, then PRONTO. vendas increments on this transition.
//  PRONTO: T_PRONTO cycles, then OCIOSO.
//  ERRO: T_ERRO cycles, then OCIOSO.
//  Leaving PRONTO or ERRO clears sel_bt and sel_cedulas to 0.
//  Timer width: $clog2(max(T_PREPARO,T_PRONTO,T_ERRO)+1). The timer reloads to 0 on every
//    state entry.
//  Latency: rise sampled at edge n -> VERIFICA at n+1 -> preparando high from n+2 for
//    T_PREPARO cycles.
//  Input changes after latching (switches moved mid-cycle) have no effect until the next
//    OCIOSO acceptance.
//  All outputs are registered or decoded from state only. No output depends combinationally
//    on bt.
// CONFIGURATION
//  CONTADOR_VENDAS_EN defined: vendas is an 8-bit register counting PREPARA->PRONTO
//    transitions. It saturates at 255 and is cleared only by rst.
//  CONTADOR_VENDAS_EN undefined: no counter logic is built. vendas is tied to 8'd0.
//    The port remains present.
// TESTING
//  1. cedulas=001, pulse bt=1000 with a real verifier -> VERIFICA, then preparando high
//     8 cycles with bebida=1000, then pronto 4 cycles, then idle. vendas=1 (EN).
//  2. cedulas=010, bt=1000 (mismatch, D_valor=1) -> erro high 4 cycles. preparando never
//     high. vendas unchanged.
//  3. cedulas=000, bt=0001 -> ERRO even though D_valor=0. Also bt=0110 rising together
//     -> ERRO.
//  4. Hold bt=0100 through the whole cycle, and press bt=0010 during PREPARA -> exactly
//     one dispense and no retrigger. Releasing and re-pressing in OCIOSO starts a new cycle.
//  5. Assert rst during PREPARA with bt held -> all outputs 0 asynchronously. After
//     release, no trigger until bt drops and rises again.
//  6. 256 valid sales with CONTADOR_VENDAS_EN -> vendas saturates at 255. Without the
//     macro -> vendas always 0.

Source files
------------

// File: rtl/controle_dispensador_if.sv
// Bus between the dispense controller and the purchase verifier.
// The controller presents the latched button/bill selection and the
// verifier answers with D_valor (0 = value accepted, 1 = mismatch).
interface controle_dispensador_if;
  logic [3:0] sel_bt;
  logic [2:0] sel_cedulas;
  logic       D_valor;

  // Dispense controller side: drives the selection, reads the verdict
  modport master (
    output sel_bt,
    output sel_cedulas,
    input  D_valor
  );

  // Verifier side: reads the selection, drives the verdict
  modport slave (
    input  sel_bt,
    input  sel_cedulas,
    output D_valor
  );
endinterface

// File: rtl/controle_dispensador.sv
// Dispense controller for the coffee vending machine.
// Detects a drink-button rise, latches the button and bill switches for
// the purchase verifier, then runs a timed preparation cycle or an error
// indication depending on the verifier answer and the selection sanity.
// Optional feature macro: CONTADOR_VENDAS_EN enables the saturating
// completed-sale counter on 'vendas'; without it 'vendas' is tied to 0.
module controle_dispensador #(
  parameter int T_PREPARO = 8,
  parameter int T_PRONTO  = 4,
  parameter int T_ERRO    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             bt,
  input  logic [2:0]             chaves_cedulas,
  controle_dispensador_if.master verif,
  output logic [3:0]             bebida,
  output logic                   preparando,
  output logic                   pronto,
  output logic                   erro,
  output logic                   ocupado,
  output logic [7:0]             vendas
);

  localparam int T_MAX_A = (T_PREPARO > T_PRONTO) ? T_PREPARO : T_PRONTO;
  localparam int T_MAX   = (T_MAX_A > T_ERRO) ? T_MAX_A : T_ERRO;
  localparam int TW      = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] ULT_PREPARO = TW'(T_PREPARO - 1);
  localparam logic [TW-1:0] ULT_PRONTO  = TW'(T_PRONTO - 1);
  localparam logic [TW-1:0] ULT_ERRO    = TW'(T_ERRO - 1);

  typedef enum logic [2:0] {
    OCIOSO,
    VERIFICA,
    PREPARA,
    PRONTO,
    ERRO
  } estado_t;

  estado_t       estado;
  logic [TW-1:0] timer;
  logic [3:0]    bt_prev;
  logic [3:0]    rise;
  logic          selecao_invalida;
  logic          prepara_fim;

  // A button counts only on its 0->1 transition; bt_prev resets to all ones
  // so a button held through reset never looks like a new press.
  assign rise = bt & ~bt_prev;

  // Selection is rejected for multi-button presses, no bill value, or a
  // verifier mismatch; the verifier sees the registered sel_* outputs.
  assign selecao_invalida = ($countones(verif.sel_bt) != 1) ||
                            (verif.sel_cedulas == 3'b000) ||
                            verif.D_valor;

  assign prepara_fim = (estado == PREPARA) && (timer == ULT_PREPARO);

  // Main controller: state, timer, latched selection and all status
  // outputs are updated together so every output is a registered value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado            <= OCIOSO;
      timer             <= '0;
      bt_prev           <= 4'b1111;
      verif.sel_bt      <= 4'b0000;
      verif.sel_cedulas <= 3'b000;
      bebida            <= 4'b0000;
      preparando        <= 1'b0;
      pronto            <= 1'b0;
      erro              <= 1'b0;
      ocupado           <= 1'b0;
    end else begin
      bt_prev <= bt;
      case (estado)
        OCIOSO: begin
          if (rise != 4'b0000) begin
            verif.sel_bt      <= bt;
            verif.sel_cedulas <= chaves_cedulas;
            estado            <= VERIFICA;
            timer             <= '0;
            ocupado           <= 1'b1;
          end
        end

        VERIFICA: begin
          timer <= '0;
          if (selecao_invalida) begin
            estado <= ERRO;
            erro   <= 1'b1;
          end else begin
            estado     <= PREPARA;
            preparando <= 1'b1;
            bebida     <= verif.sel_bt;
          end
        end

        PREPARA: begin
          if (prepara_fim) begin
            estado     <= PRONTO;
            timer      <= '0;
            preparando <= 1'b0;
            pronto     <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        PRONTO: begin
          if (timer == ULT_PRONTO) begin
            estado            <= OCIOSO;
            timer             <= '0;
            pronto            <= 1'b0;
            bebida            <= 4'b0000;
            ocupado           <= 1'b0;
            verif.sel_bt      <= 4'b0000;
            verif.sel_cedulas <= 3'b000;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ERRO: begin
          if (timer == ULT_ERRO) begin
            estado            <= OCIOSO;
            timer             <= '0;
            erro              <= 1'b0;
            ocupado           <= 1'b0;
            verif.sel_bt      <= 4'b0000;
            verif.sel_cedulas <= 3'b000;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          estado     <= OCIOSO;
          timer      <= '0;
          bebida     <= 4'b0000;
          preparando <= 1'b0;
          pronto     <= 1'b0;
          erro       <= 1'b0;
          ocupado    <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONTADOR_VENDAS_EN
  // Completed-sale counter: one count per finished preparation, holds at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vendas <= 8'd0;
    end else if (prepara_fim && (vendas != 8'd255)) begin
      vendas <= vendas + 8'd1;
    end
  end
`else
  assign vendas = 8'd0;
`endif

endmodule

// File: tb/tb_controle_dispensador.sv
// Directed testbench for controle_dispensador with a small price-table
// model of the purchase verifier driving D_valor from the sel_* bus.
// Expected vendas follows CONTADOR_VENDAS_EN the same way as the design.
module tb_controle_dispensador;

  localparam int T_PREPARO = 8;
  localparam int T_PRONTO  = 4;
  localparam int T_ERRO    = 4;

  logic       clk;
  logic       rst;
  logic [3:0] bt;
  logic [2:0] chaves_cedulas;
  logic [3:0] bebida;
  logic       preparando;
  logic       pronto;
  logic       erro;
  logic       ocupado;
  logic [7:0] vendas;

  logic       force_ok;
  logic [2:0] preco;

  int checks;
  int errors;
  int sales;

  controle_dispensador_if verif ();

  controle_dispensador #(
    .T_PREPARO(T_PREPARO),
    .T_PRONTO (T_PRONTO),
    .T_ERRO   (T_ERRO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bt            (bt),
    .chaves_cedulas(chaves_cedulas),
    .verif         (verif.master),
    .bebida        (bebida),
    .preparando    (preparando),
    .pronto        (pronto),
    .erro          (erro),
    .ocupado       (ocupado),
    .vendas        (vendas)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Verifier model: each drink has one accepted bill code
  always_comb begin
    preco = 3'b111;
    case (verif.sel_bt)
      4'b1000: preco = 3'b001;
      4'b0100: preco = 3'b010;
      4'b0010: preco = 3'b011;
      4'b0001: preco = 3'b100;
      default: preco = 3'b111;
    endcase
  end

  assign verif.D_valor = force_ok ? 1'b0 : (verif.sel_cedulas != preco);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic [2:0] c);
    bt             = b;
    chaves_cedulas = c;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] dutStatus();
    return {verif.sel_bt, verif.sel_cedulas, bebida, preparando, pronto, erro, ocupado};
  endfunction

  function automatic logic [7:0] vendasEsperadas();
`ifdef CONTADOR_VENDAS_EN
    return (sales > 255) ? 8'd255 : 8'(sales);
`else
    return 8'd0;
`endif
  endfunction

  // Press b with bills c, keep hold_bt after latching, apply mid_bt/mid_ced
  // in the middle of PREPARA, and check every cycle until back in OCIOSO.
  task automatic runCycle(input logic [3:0] b, input logic [2:0] c, input bit exp_ok,
                          input logic [3:0] hold_bt, input logic [3:0] mid_bt,
                          input logic [2:0] mid_ced);
    applyStimulus(b, c);
    stepCycle();
    checkOutput("verifica", 32'(dutStatus()), 32'({b, c, 8'h01}));
    applyStimulus(hold_bt, c);
    if (exp_ok) begin
      for (int i = 0; i < T_PREPARO; i++) begin
        stepCycle();
        checkOutput("preparando", 32'(dutStatus()), 32'({b, c, b, 4'b1001}));
        if (i == 2) applyStimulus(mid_bt, mid_ced);
      end
      sales++;
      for (int i = 0; i < T_PRONTO; i++) begin
        stepCycle();
        checkOutput("pronto", 32'(dutStatus()), 32'({b, c, b, 4'b0101}));
      end
    end else begin
      for (int i = 0; i < T_ERRO; i++) begin
        stepCycle();
        checkOutput("erro", 32'(dutStatus()), 32'({b, c, 4'h0, 4'b0011}));
      end
    end
    stepCycle();
    checkOutput("ocioso", 32'(dutStatus()), 32'd0);
    checkOutput("vendas", 32'(vendas), 32'(vendasEsperadas()));
  endtask

  // Directed scenario sequence
  initial begin
    checks   = 0;
    errors   = 0;
    sales    = 0;
    force_ok = 1'b0;
    rst      = 1'b1;
    applyStimulus(4'b0000, 3'b000);

    stepCycle();
    stepCycle();
    checkOutput("reset_status", 32'(dutStatus()), 32'd0);
    checkOutput("reset_vendas", 32'(vendas), 32'd0);
    rst = 1'b0;
    stepCycle();
    checkOutput("idle_after_reset", 32'(dutStatus()), 32'd0);

    $display("[TB] valid expresso sale");
    runCycle(4'b1000, 3'b001, 1'b1, 4'b0000, 4'b0000, 3'b001);

    $display("[TB] verifier mismatch");
    runCycle(4'b1000, 3'b010, 1'b0, 4'b0000, 4'b0000, 3'b010);

    $display("[TB] zero bills and double press");
    force_ok = 1'b1;
    runCycle(4'b0001, 3'b000, 1'b0, 4'b0000, 4'b0000, 3'b000);
    runCycle(4'b0110, 3'b010, 1'b0, 4'b0000, 4'b0000, 3'b010);
    force_ok = 1'b0;

    $display("[TB] held button and press during preparation");
    runCycle(4'b0100, 3'b010, 1'b1, 4'b0100, 4'b0110, 3'b000);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("no_retrigger", 32'(dutStatus()), 32'd0);
    end
    applyStimulus(4'b0000, 3'b010);
    stepCycle();
    runCycle(4'b0100, 3'b010, 1'b1, 4'b0000, 4'b0000, 3'b010);

    $display("[TB] reset during preparation");
    applyStimulus(4'b0100, 3'b010);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("prep_before_rst", 32'(dutStatus()), 32'({4'b0100, 3'b010, 4'b0100, 4'b1001}));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_status", 32'(dutStatus()), 32'd0);
    checkOutput("async_rst_vendas", 32'(vendas), 32'd0);
    sales = 0;
    stepCycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("held_through_rst", 32'(dutStatus()), 32'd0);
    end
    applyStimulus(4'b0000, 3'b010);
    stepCycle();
    runCycle(4'b0100, 3'b010, 1'b1, 4'b0000, 4'b0000, 3'b010);

    $display("[TB] sale counter saturation");
    for (int n = 0; n < 256; n++) begin
      runCycle(4'b1000, 3'b001, 1'b1, 4'b0000, 4'b0000, 3'b001);
    end
`ifdef CONTADOR_VENDAS_EN
    checkOutput("vendas_saturated", 32'(vendas), 32'd255);
`else
    checkOutput("vendas_disabled", 32'(vendas), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
